// File: rtl/fir_tdm_multi.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks every channel's
// delay line per frame strobe, then all channel outputs update together.
module fir_tdm_multi #(
  parameter int CHANNELS = 2,
  parameter int W        = 24,
  parameter int M        = 16,
  parameter int DELAYS   = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] x_in [CHANNELS],
  input  logic signed [M-1:0] b [DELAYS+1],
  input  logic                ena,
  input  logic                bypass,
  input  logic                next_lrclk_fall,
  output logic signed [W-1:0] y_out [CHANNELS],
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);
  localparam int TAPS = DELAYS + 1;
  localparam int PW   = W + M;
  localparam int AW   = PW + ((TAPS > 1) ? $clog2(TAPS) : 0);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MAC    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  // Floor-shift back to sample scale, then clamp to the signed W-bit range.
  function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> (M-1);
    if (s > SMAX)      sat = SMAX[W-1:0];
    else if (s < SMIN) sat = SMIN[W-1:0];
    else               sat = s[W-1:0];
  endfunction

  logic [1:0]          state;
  logic [CW-1:0]       ch_cnt;
  logic [TW-1:0]       tap_cnt;
  logic                drain_cnt;
  logic                byp_frame;
  logic                accept;
  logic signed [W-1:0] dl [CHANNELS][TAPS];
  logic signed [M-1:0] coef [TAPS];

  logic signed [PW-1:0] prod_p0;
  logic                 vld_p0, first_p0, last_p0;
  logic [CW-1:0]        ch_p0;
  logic signed [AW-1:0] acc_p1;
  logic                 vld_p1;
  logic [CW-1:0]        ch_p1;
  logic signed [W-1:0]  res_p2 [CHANNELS];

  assign accept = next_lrclk_fall && ena && (state == IDLE);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch_cnt    <= '0;
      tap_cnt   <= '0;
      drain_cnt <= 1'b0;
      byp_frame <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      vld_p0    <= (state == MAC);
      vld_p1    <= vld_p0 && last_p0;
      if (next_lrclk_fall && ena && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          byp_frame <= bypass;
          ch_cnt    <= '0;
          tap_cnt   <= '0;
          drain_cnt <= 1'b0;
          state     <= bypass ? UPDATE : MAC;
        end
        MAC: if (tap_cnt == TW'(DELAYS)) begin
          tap_cnt <= '0;
          if (ch_cnt == CW'(CHANNELS-1)) state <= DRAIN;
          else ch_cnt <= ch_cnt + 1'b1;
        end else begin
          tap_cnt <= tap_cnt + 1'b1;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= UPDATE;
        end
        UPDATE: begin
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: registered product of the current channel/tap.
  always_ff @(posedge clk) begin
    prod_p0  <= PW'(dl[ch_cnt][tap_cnt]) * PW'(coef[tap_cnt]);
    first_p0 <= (tap_cnt == '0);
    last_p0  <= (tap_cnt == TW'(DELAYS));
    ch_p0    <= ch_cnt;
  end

  // Stage p1: accumulate; the first tap of a channel restarts the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1 <= '0;
    end else if (vld_p0) begin
      acc_p1 <= first_p0 ? AW'(prod_p0) : acc_p1 + AW'(prod_p0);
    end
    if (vld_p0) ch_p1 <= ch_p0;
  end

  // Stage p2: saturated per-channel result, held until the joint update.
  always_ff @(posedge clk) begin
    if (vld_p1) res_p2[ch_p1] <= sat(acc_p1);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= b[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        y_out[c] <= '0;
        for (int k = 0; k < TAPS; k++) dl[c][k] <= '0;
      end
    end else begin
      if (accept) begin
        for (int c = 0; c < CHANNELS; c++) begin
          dl[c][0] <= x_in[c];
          for (int k = 1; k < TAPS; k++) dl[c][k] <= dl[c][k-1];
        end
      end
      // A bypass frame's newest delay-line entry is exactly the captured input.
      if (state == UPDATE) begin
        for (int c = 0; c < CHANNELS; c++)
          y_out[c] <= byp_frame ? dl[c][0] : res_p2[c];
      end
    end
  end
endmodule
